// File: rtl/pe_pkg.sv
// Shared definitions for the MAC processing element.
// Holds the PE state encoding and the helpers that derive the signed
// saturation bounds for any accumulator width up to PE_MAX_ACC_W bits.
package pe_pkg;

  typedef enum logic {
    PE_IDLE = 1'b0,
    PE_ACC  = 1'b1
  } pe_state_e;

  localparam int PE_MAX_ACC_W = 64;
  localparam logic [PE_MAX_ACC_W-1:0] PE_ALL_ONES = '1;

  // Largest positive value of a w-bit two's-complement number, zero-extended
  // to PE_MAX_ACC_W bits. The most negative value is its bitwise inverse.
  function automatic logic [PE_MAX_ACC_W-1:0] pe_sat_max(input int w);
    return PE_ALL_ONES >> (PE_MAX_ACC_W - w + 1);
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational signed adder of accumulator width.
// Ports:
//   a, b     : signed addends (ACC_W bits)
//   sum      : a + b, clamped to the signed range when SATURATE=1,
//              two's-complement wrapped otherwise
//   overflow : the exact sum did not fit in ACC_W bits
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int ACC_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    overflow
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(pe_sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W-1:0] raw;

  // Overflow can only happen when both addends share a sign and the
  // wrapped result's sign differs; the clamp direction follows that sign.
  always_comb begin
    raw      = a + b;
    overflow = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
    sum      = raw;
    if (SATURATE && overflow) begin
      sum = a[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/pe_mac_tile.sv
// Output-stationary MAC processing element for a systolic array tile.
// Operands move west->east and north->south through one register stage each;
// when both operands are valid they are multiplied and accumulated into a
// dot product delimited by the west first/last tags. Completed dot products
// land in a single hold register drained with a ready/valid handshake.
// Ports:
//   clk, rst                      : clock (rising edge), async active-high reset
//   in_north, in_north_valid      : north operand and its valid
//   in_west, in_west_valid        : west operand and its valid
//   in_west_first, in_west_last   : dot-product delimiters, qualified by west valid
//   out_south, out_south_valid    : registered copy of the north operand
//   out_east, out_east_valid,
//   out_east_first, out_east_last : registered copy of the west operand and tags
//   relu_en                       : clamp negative results to zero at load time
//   result_data, result_valid     : held dot product and its valid
//   result_ready                  : consumer accepts result_data
//   result_sat                    : the held result saturated along the way
//   err_align                     : sticky operand alignment / tagging error
//   err_drop                      : sticky, a completed result was discarded
//   acc_busy                      : a dot product is being accumulated
module pe_mac_tile
  import pe_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_north,
  input  logic                     in_north_valid,
  input  logic signed [DATA_W-1:0] in_west,
  input  logic                     in_west_valid,
  input  logic                     in_west_first,
  input  logic                     in_west_last,
  output logic signed [DATA_W-1:0] out_south,
  output logic                     out_south_valid,
  output logic signed [DATA_W-1:0] out_east,
  output logic                     out_east_valid,
  output logic                     out_east_first,
  output logic                     out_east_last,
  input  logic                     relu_en,
  output logic signed [ACC_W-1:0]  result_data,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     result_sat,
  output logic                     err_align,
  output logic                     err_drop,
  output logic                     acc_busy
);

  pe_state_e state, state_next;

  logic signed [ACC_W-1:0]    acc, acc_next;
  logic                       sat_flag, sat_next;
  logic signed [2*DATA_W-1:0] product;
  logic signed [ACC_W-1:0]    product_ext;
  logic signed [ACC_W-1:0]    sum;
  logic                       overflow;
  logic                       clamp;
  logic                       fire;
  logic                       mismatch;
  logic                       load;
  logic signed [ACC_W-1:0]    load_value;
  logic                       load_sat;
  logic                       align_err;
  logic                       can_load;

  assign fire     = in_north_valid && in_west_valid;
  assign mismatch = in_north_valid ^ in_west_valid;

  // Widen before multiplying so the full signed product is kept, then
  // sign-extend into the accumulator width.
  assign product     = (2*DATA_W)'(in_north) * (2*DATA_W)'(in_west);
  assign product_ext = ACC_W'(product);

  pe_sat_add #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .a        (acc),
    .b        (product_ext),
    .sum      (sum),
    .overflow (overflow)
  );

  // In wrap mode an overflow is legal arithmetic, not a saturation event.
  assign clamp = SATURATE && overflow;

  assign acc_busy = (state == PE_ACC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PE_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A first tag always starts a fresh dot product from the bare product,
  // which cannot saturate because ACC_W >= 2*DATA_W. A first seen while
  // already accumulating is flagged but still honoured as a restart.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    sat_next   = sat_flag;
    load       = 1'b0;
    load_value = product_ext;
    load_sat   = 1'b0;
    align_err  = mismatch;
    if (fire) begin
      case (state)
        PE_IDLE: begin
          if (!in_west_first) begin
            align_err = 1'b1;
          end else if (in_west_last) begin
            load = 1'b1;
          end else begin
            acc_next   = product_ext;
            sat_next   = 1'b0;
            state_next = PE_ACC;
          end
        end
        PE_ACC: begin
          if (in_west_first) begin
            align_err = 1'b1;
            sat_next  = 1'b0;
            if (in_west_last) begin
              load       = 1'b1;
              state_next = PE_IDLE;
            end else begin
              acc_next = product_ext;
            end
          end else if (in_west_last) begin
            load       = 1'b1;
            load_value = sum;
            load_sat   = sat_flag | clamp;
            sat_next   = 1'b0;
            state_next = PE_IDLE;
          end else begin
            acc_next = sum;
            sat_next = sat_flag | clamp;
          end
        end
        default: begin
          state_next = PE_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      sat_flag <= 1'b0;
    end else begin
      acc      <= acc_next;
      sat_flag <= sat_next;
    end
  end

  // Forwarding is unconditional so bubbles and stale data propagate
  // through the array exactly as they arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_south       <= '0;
      out_south_valid <= 1'b0;
      out_east        <= '0;
      out_east_valid  <= 1'b0;
      out_east_first  <= 1'b0;
      out_east_last   <= 1'b0;
    end else begin
      out_south       <= in_north;
      out_south_valid <= in_north_valid;
      out_east        <= in_west;
      out_east_valid  <= in_west_valid;
      out_east_first  <= in_west_first;
      out_east_last   <= in_west_last;
    end
  end

  // The hold slot is free when empty or being drained this very cycle, so
  // an accept and a load on the same edge hand over without a bubble.
  assign can_load = !result_valid || result_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_data  <= '0;
      result_valid <= 1'b0;
      result_sat   <= 1'b0;
      err_drop     <= 1'b0;
    end else if (load && can_load) begin
      result_data  <= (relu_en && load_value[ACC_W-1]) ? '0 : load_value;
      result_sat   <= load_sat;
      result_valid <= 1'b1;
    end else begin
      if (load) begin
        err_drop <= 1'b1;
      end
      if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_align <= 1'b0;
    end else if (align_err) begin
      err_align <= 1'b1;
    end
  end

endmodule
